alu_seq_ctrl: RTL

Multi-cycle ALU sequencer for the area-reduced core variant. It accepts one ALU operation at a time over a valid/ready request channel. Single-cycle ops (add, sub, slt, sltu, xor, or, and) complete in one cycle. Shifts (sll, srl, sra) are executed serially, one bit position per cycle, so the barrel shifter can be removed. The result is returned on a valid/ready response channel toward writeback.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_decode.sv | 23 ++
 rtl/alu_seq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op encodings, sequencer state and op-class types for the serial-shift ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } shift_kind_t;

    // One-hot op class; all-zero means the encoding is illegal.
    typedef struct packed {
        logic arith;
        logic cmp;
        logic logic_op;
        logic shift;
    } op_class_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Classifies a 4-bit alu_ctr encoding into a one-hot op class.
module alu_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        if (is_shift(op)) begin
            op_class.shift = 1'b1;
        end else begin
            case (op)
                ALU_ADD, ALU_SUB:        op_class.arith    = 1'b1;
                ALU_SLT, ALU_SLTU:       op_class.cmp      = 1'b1;
                ALU_XOR, ALU_OR, ALU_AND: op_class.logic_op = 1'b1;
                default:                 op_class          = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: single-cycle arithmetic/logic ops, shifts done one bit per cycle.
// Request handshake: a transfer happens on a rising edge where valid && ready (and no flush);
// ready/valid outputs are decoded from state only, so there is no input-to-output comb path.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_err,
    input  logic            flush,
    output logic            busy
);

    seq_state_t      state;
    shift_kind_t     shift_kind;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] result;
    logic            err;

    op_class_t       op_class;
    logic            legal;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shift_next;
    logic [SHW-1:0]  shamt;
    shift_kind_t     req_kind;

    alu_decode u_decode (
        .op       (req_op),
        .op_class (op_class)
    );

    assign legal = |op_class;
    assign shamt = req_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (req_op)
            ALU_ADD:  alu_res = req_a + req_b;
            ALU_SUB:  alu_res = req_a - req_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(req_a) < $signed(req_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, req_a < req_b};
            ALU_XOR:  alu_res = req_a ^ req_b;
            ALU_OR:   alu_res = req_a | req_b;
            ALU_AND:  alu_res = req_a & req_b;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        req_kind = SK_SRA;
        if (req_op == ALU_SLL)      req_kind = SK_SLL;
        else if (req_op == ALU_SRL) req_kind = SK_SRL;
    end

    // One bit position per cycle replaces the barrel shifter.
    always_comb begin
        shift_next = result;
        case (shift_kind)
            SK_SLL:  shift_next = {result[XLEN-2:0], 1'b0};
            SK_SRL:  shift_next = {1'b0, result[XLEN-1:1]};
            SK_SRA:  shift_next = {result[XLEN-1], result[XLEN-1:1]};
            default: shift_next = result;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift_kind <= SK_SLL;
            cnt        <= '0;
            result     <= '0;
            err        <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!legal) begin
                            result <= '0;
                            err    <= 1'b1;
                            state  <= ST_DONE;
                        end else if (op_class.shift) begin
                            err        <= 1'b0;
                            result     <= req_a;
                            shift_kind <= req_kind;
                            if (shamt == '0) begin
                                state <= ST_DONE;
                            end else begin
                                cnt   <= shamt;
                                state <= ST_SHIFT;
                            end
                        end else begin
                            err    <= 1'b0;
                            result <= alu_res;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    result <= shift_next;
                    cnt    <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (state == ST_IDLE);
    assign resp_valid  = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);
    assign resp_result = result;
    assign resp_err    = err;

endmodule
